// File: rtl/main_tx.sv
// main_tx: skid-buffered transmit flow controller feeding the router main FIFO
// through push_main/data_in, honouring the registered pause and a per-burst gap.
module main_tx #(
    parameter int unsigned DATA_SIZE = 6,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned BURST_MAX = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic                 in_ready,
    input  logic                 enable,
    input  logic                 pause,
    output logic                 push_main,
    output logic [DATA_SIZE-1:0] data_in,
    output logic [7:0]           tx_count,
    output logic                 buf_empty,
    output logic [1:0]           state
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        HOLD = 2'b10,
        GAP  = 2'b11
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [DATA_SIZE-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic [7:0]           r_burst;
    logic [7:0]           r_tx_count;
    logic                 r_push_main;
    logic [DATA_SIZE-1:0] r_data_in;
    logic                 w_write;
    logic                 w_issue;
    logic                 w_nonempty;
    logic                 w_drains;
    logic                 w_burst_done;

    assign w_nonempty   = (r_count != '0);
    assign in_ready     = !reset && (r_count < CW'(DEPTH));
    assign w_write      = in_valid && in_ready;
    assign w_issue      = (r_state == SEND) && enable && !pause && w_nonempty;
    // Buffer is dry after this cycle: already empty, or the last word leaves unreplaced
    assign w_drains     = !w_nonempty || ((r_count == CW'(1)) && !w_write);
    assign w_burst_done = w_issue && (({1'b0, r_burst} + 9'd1) == 9'(BURST_MAX));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (enable && !pause && w_nonempty) w_next_state = SEND;
            SEND: begin
                if (pause)                     w_next_state = HOLD;
                else if (!enable || w_drains)  w_next_state = IDLE;
                else if (w_burst_done)         w_next_state = GAP;
            end
            HOLD: if (!pause) w_next_state = (enable && w_nonempty) ? SEND : IDLE;
            GAP: begin
                if (pause)                       w_next_state = HOLD;
                else if (enable && w_nonempty)   w_next_state = SEND;
                else                             w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_burst     <= '0;
            r_tx_count  <= '0;
            r_push_main <= 1'b0;
            r_data_in   <= '0;
        end else begin
            if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_issue) begin
                r_rd_ptr    <= r_rd_ptr + AW'(1);
                r_tx_count  <= r_tx_count + 8'd1;
                r_data_in   <= r_mem[r_rd_ptr];
                r_push_main <= 1'b1;
            end else begin
                r_push_main <= 1'b0;
            end
            if (w_write && !w_issue)      r_count <= r_count + CW'(1);
            else if (!w_write && w_issue) r_count <= r_count - CW'(1);
            // Any break in sending (gap, idle, hold) restarts the burst
            if (r_state == GAP || w_next_state == IDLE || w_next_state == HOLD)
                r_burst <= '0;
            else if (w_issue)
                r_burst <= r_burst + 8'd1;
        end
    end

    assign push_main = r_push_main;
    assign data_in   = r_data_in;
    assign tx_count  = r_tx_count;
    assign buf_empty = !w_nonempty;
    assign state     = r_state;
endmodule

// File: tb/tb_main_tx.sv
// Self-checking bench for main_tx: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_main_tx;
    localparam int DW    = 6;
    localparam int DEPTH = 4;
    localparam int BURST = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          enable = 1'b0;
    logic          pause = 1'b0;
    logic          in_ready;
    logic          push_main;
    logic [DW-1:0] data_in;
    logic [7:0]    tx_count;
    logic          buf_empty;
    logic [1:0]    state;

    main_tx #(.DATA_SIZE(DW), .DEPTH(DEPTH), .BURST_MAX(BURST)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .enable(enable), .pause(pause),
        .push_main(push_main), .data_in(data_in), .tx_count(tx_count),
        .buf_empty(buf_empty), .state(state)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE = 0, M_SEND = 1, M_HOLD = 2, M_GAP = 3} mst_t;
    mst_t          ms = M_IDLE;
    int            mburst = 0;
    int            mtx = 0;
    bit            mpush = 1'b0;
    logic [DW-1:0] mdout = '0;
    logic [DW-1:0] bq[$];

    int  n_checks = 0;
    int  n_pass = 0;
    bit  chk_en = 1'b0;
    int  cur_run, zeros;
    int  runs[$];
    int  gaps[$];
    logic [DW-1:0] seen[$];

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference: the buffer is a plain queue; a word leaves when the controller
    // is sending, allowed, and has something; the mode follows the next-cycle rules.
    task automatic model_clock();
        int   n;
        int   n_after;
        bit   wr;
        bit   iss;
        mst_t nx;
        if (reset) begin
            bq.delete();
            ms = M_IDLE; mburst = 0; mtx = 0; mpush = 1'b0; mdout = '0;
        end else begin
            n       = bq.size();
            wr      = in_valid && (n < DEPTH);
            iss     = (ms == M_SEND) && enable && !pause && (n != 0);
            n_after = n + int'(wr) - int'(iss);
            nx      = ms;
            case (ms)
                M_IDLE: if (enable && !pause && n != 0) nx = M_SEND;
                M_SEND: begin
                    if (pause)                              nx = M_HOLD;
                    else if (!enable || n_after == 0)       nx = M_IDLE;
                    else if (iss && mburst + 1 == BURST)    nx = M_GAP;
                end
                M_HOLD: if (!pause) nx = (enable && n != 0) ? M_SEND : M_IDLE;
                default: begin
                    if (pause)                  nx = M_HOLD;
                    else if (enable && n != 0)  nx = M_SEND;
                    else                        nx = M_IDLE;
                end
            endcase
            if (iss) begin
                mdout = bq.pop_front();
                mtx   = (mtx + 1) % 256;
                mpush = 1'b1;
            end else begin
                mpush = 1'b0;
            end
            if (wr) bq.push_back(in_data);
            if (ms == M_GAP || nx == M_IDLE || nx == M_HOLD) mburst = 0;
            else if (iss) mburst++;
            ms = nx;
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                        input logic en, input logic p);
        reset = r; in_valid = v; in_data = d; enable = en; pause = p;
        @(posedge clk);
        model_clock();
        #1;
        chk_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  in_ready,  int'(!reset && bq.size() < DEPTH));
            chk("push_main", push_main, mpush);
            chk("data_in",   data_in,   mdout);
            chk("tx_count",  tx_count,  mtx);
            chk("buf_empty", buf_empty, int'(bq.size() == 0));
            chk("state",     state,     int'(ms));
        end
    end

    task automatic start_collect();
        runs.delete(); gaps.delete(); seen.delete();
        cur_run = 0; zeros = 0;
    endtask

    task automatic collect();
        if (push_main) begin
            seen.push_back(data_in);
            if (cur_run == 0 && runs.size() > 0) gaps.push_back(zeros);
            cur_run++;
            zeros = 0;
        end else begin
            if (cur_run > 0) begin
                runs.push_back(cur_run);
                cur_run = 0;
            end
            zeros++;
        end
    endtask

    task automatic order_check(input string nm, input int expn, input int base);
        int nbad;
        nbad = 0;
        chk({nm, "_count"}, seen.size(), expn);
        for (int i = 0; i < seen.size(); i++)
            if (seen[i] != DW'(base + i)) nbad++;
        chk({nm, "_order_errors"}, nbad, 0);
    endtask

    initial begin
        int exp_runs[3];
        int acc;
        int guard;
        bit w;
        exp_runs = '{8, 8, 4};

        // Reset held with traffic offered
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, DW'(i), 1'b1, 1'b0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_push", push_main, 0);
            chk("rst_tx_count", tx_count, 0);
            chk("rst_state", state, 0);
        end
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Single word: accepted in cycle n, pushed in cycle n+3
        step(1'b0, 1'b1, 6'h2A, 1'b1, 1'b0);
        chk("single_n1_push", push_main, 0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("single_n2_push", push_main, 0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("single_n3_push", push_main, 1);
        chk("single_n3_data", data_in, 6'h2A);
        chk("single_tx_count", tx_count, 1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("single_empty", buf_empty, 1);

        // Burst gap: 20 continuous words -> runs 8, 8, 4 separated by single idles
        step(1'b1, 1'b0, '0, 1'b1, 1'b0);
        start_collect();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, DW'(i), 1'b1, 1'b0);
            collect();
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b0);
            collect();
        end
        if (cur_run > 0) runs.push_back(cur_run);
        chk("burst_nruns", runs.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("burst_run%0d", i), (i < runs.size()) ? runs[i] : 0, exp_runs[i]);
        chk("burst_ngaps", gaps.size(), 2);
        for (int i = 0; i < 2; i++)
            chk($sformatf("burst_gap%0d", i), (i < gaps.size()) ? gaps[i] : 0, 1);
        order_check("burst", 20, 0);
        chk("burst_tx_count", tx_count, 20);

        // Pause mid-stream for 5 cycles
        step(1'b1, 1'b0, '0, 1'b1, 1'b0);
        start_collect();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, DW'(i), 1'b1, 1'b0);
            collect();
        end
        for (int i = 6; i < 11; i++) begin
            step(1'b0, 1'b1, DW'(i), 1'b1, 1'b1);
            collect();
        end
        chk("pause_state_hold", state, 2);
        chk("pause_full_ready", in_ready, 0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        collect();
        chk("resume_m1_push", push_main, 0);
        chk("resume_m1_state", state, 1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        collect();
        chk("resume_m2_push", push_main, 1);
        chk("resume_m2_data", data_in, 4);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b0);
            collect();
        end
        order_check("pause", 8, 0);
        chk("pause_tx_count", tx_count, 8);

        // Full boundary with enable low, then release with in_valid held
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, DW'(16 + i), 1'b0, 1'b0);
        chk("full_ready", in_ready, 0);
        step(1'b0, 1'b1, 6'h30, 1'b1, 1'b0);
        chk("full_a1_ready", in_ready, 0);
        chk("full_a1_state", state, 1);
        step(1'b0, 1'b1, 6'h30, 1'b1, 1'b0);
        chk("full_a2_ready", in_ready, 1);
        chk("full_a2_data", data_in, 16);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, DW'(49 + i), 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Reset asserted during a burst
        step(1'b1, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, DW'(32 + i), 1'b1, 1'b0);
        chk("midrst_pre_push", push_main, 1);
        step(1'b1, 1'b1, 6'h3F, 1'b1, 1'b0);
        chk("midrst_push", push_main, 0);
        chk("midrst_empty", buf_empty, 1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // tx_count wrap: 260 accepted words
        step(1'b1, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        acc = 0;
        guard = 0;
        while (acc < 260 && guard < 2000) begin
            w = in_ready;
            step(1'b0, 1'b1, DW'(acc), 1'b1, 1'b0);
            if (w) acc++;
            guard++;
        end
        chk("wrap_accepted", acc, 260);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("wrap_tx_count", tx_count, 4);
        chk("wrap_empty", buf_empty, 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0),
                 DW'($urandom),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 4) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/main_tx.md
# main_tx

Transmit-side flow controller that feeds the router's main FIFO. It accepts 6-bit words from an upstream source over a valid/ready handshake and stores them in a small skid buffer. It pushes them into the main FIFO through `push_main`/`data_in`, honoring the router's registered `pause` and a per-burst gap rule. It sits outside the router, on the opposite side of the `push_main`/`pause` interface.

## Interface
- `DATA_SIZE`, 6, word width; matches the router's `data_in`.
- `DEPTH`, 4, skid buffer entries; power of two, ≥2.
- `BURST_MAX`, 8, maximum consecutive pushes before one forced idle cycle; range 1..255.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: upstream word valid.
- `in_data` in DATA_SIZE: upstream word.
- `in_ready` out 1: buffer can accept; combinational, `!reset && count < DEPTH`.
- `enable` in 1: 0 stops issuing new pushes; buffered words are retained.
- `pause` in 1: router main-FIFO pause, already registered by the router.
- `push_main` out 1: registered push strobe to the router.
- `data_in` out DATA_SIZE: registered word to the router; valid only when `push_main`=1.
- `tx_count` out 8: total words pushed; wraps modulo 256.
- `buf_empty` out 1: skid buffer empty (count == 0).
- `state` out 2: FSM state, for debug and verification.

## Operation
- **Skid buffer:** circular buffer of DEPTH entries with `wr_ptr`, `rd_ptr` and a `count` of width log2(DEPTH)+1.
  - Write when `in_valid && in_ready`.
  - Pop when `issue`=1.
  - Simultaneous write and pop leaves `count` unchanged.
  - There is no pass-through: a word written in cycle n is poppable in cycle n+1 at the earliest.
  - While full, `in_ready`=0 even if a pop occurs in the same cycle.
- **Issue condition:** `issue = (state==SEND) && enable && !pause && count!=0`.
  - On an `issue` cycle: `push_main` <= 1, `data_in` <= head word, `rd_ptr`++, `tx_count`++, `burst`++.
  - Otherwise: `push_main` <= 0 and `data_in` holds its last value.
- **FSM states:** IDLE=00, SEND=01, HOLD=10, GAP=11. Transitions are evaluated per cycle, first match wins.
  - **IDLE:**
    - `enable && !pause && count!=0` → SEND.
    - Else stay.
  - **SEND:**
    - `pause` → HOLD.
    - `!enable` or (`count`==0) or (`count`==1 with no write this cycle, after the issue) → IDLE.
    - Issue makes `burst`==BURST_MAX → GAP.
    - Else stay.
  - **HOLD:** no issue.
    - `!pause && enable && count!=0` → SEND.
    - `!pause` otherwise → IDLE.
    - Else stay.
  - **GAP:** exactly one cycle with no issue.
    - Clear `burst`.
    - Then `pause` → HOLD; else if `enable && count!=0` → SEND; else IDLE.
- **Burst counter:**
  - `burst` is 8 bits and counts issues since the last GAP.
  - It clears on entering IDLE or HOLD, since any break resets the burst.
- **Reset:**
  - While `reset`=1: state=IDLE, pointers, `count`, `burst`, `tx_count` = 0; `push_main`=0, `data_in`=0, `in_ready`=0.
  - A reset asserted mid-burst discards buffered words.
  - A push already registered in the reset cycle is cleared at the same edge.

## Timing
- Latency: a word accepted in cycle n with the FSM in IDLE shows `push_main`=1 in cycle n+3.
  - n+1: buffer non-empty, IDLE→SEND.
  - n+2: issue.
  - n+3: registered output.
- Back-to-back: in SEND with data available, one push per cycle for up to BURST_MAX cycles, then one idle cycle.
- Pause reaction:
  - `pause` sampled high in cycle n suppresses issue in cycle n.
  - The last possible `push_main` is in cycle n, from the cycle n-1 issue.
  - Router pause is itself registered, so the main FIFO receives up to 2 words after its threshold is crossed. The main-FIFO almost-full setting must leave ≥2 entries of margin.
- Resume: `pause` falling in cycle m (HOLD) → SEND in m+1 → `push_main` in m+2.
- `in_ready` is combinational from registered `count` only; it has no path from `in_valid`.

## Test plan
- **Reset values:** hold `reset`=1 for 3 cycles with `in_valid`=1 → `in_ready`=0, `push_main`=0, `tx_count`=0, `state`=00 throughout.
- **Single word:** write 0x2A at cycle 5 with `enable`=1 and `pause`=0 → `push_main`=1 with `data_in`=0x2A exactly at cycle 8, `tx_count`=1, `buf_empty`=1 afterward.
- **Burst gap:** BURST_MAX=8, continuous writes of 0..19 → pushes in runs of 8, 8 and 4, each 8-run followed by exactly one `push_main`=0 cycle; data in order; `tx_count`=20.
- **Pause:** raise `pause` mid-stream for 5 cycles → no issue while `pause`=1, `state`=10, buffer fills to 4 and `in_ready`=0; after `pause` falls, pushes resume in 2 cycles with no word lost or duplicated.
- **Full boundary:** fill 4 words with `enable`=0 → `in_ready`=0. Then `enable`=1 with `in_valid` held → `in_ready` returns to 1 only after the first pop; order is preserved.
- **Reset mid-operation / wrap:**
  - Assert `reset` during a burst → next cycle `push_main`=0 and the buffer is empty.
  - Separately, push 260 words → `tx_count`=4.
